// File: rtl/fbf_pkg.sv
// Shared constants and state encoding for the 4x4 float matrix host.
// Ports: none (package).
package fbf_pkg;

  localparam int DIM = 4;
  localparam int WW  = 32;
  localparam int NW  = DIM * DIM;
  localparam int BW  = NW * WW;

  typedef enum logic [2:0] {
    S_LOAD_A,
    S_LOAD_B,
    S_STROBE,
    S_WAIT_RESULT,
    S_ACK,
    S_DRAIN
  } state_t;

endpackage

// File: rtl/fbf_mult_host_if.sv
// Bundle of the host's stream and multiplier-side signals.
// master = host side, slave = environment (source/multiplier/sink).
interface fbf_mult_host_if;
  import fbf_pkg::*;

  logic [WW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] mult_A;
  logic [BW-1:0] mult_B;
  logic          mult_A_stb;
  logic          mult_B_stb;
  logic [BW-1:0] mult_result;
  logic          mult_result_ready;
  logic          mult_result_ack;
  logic [WW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          timeout_err;

  modport master (
    input  in_data, in_valid,
    output in_ready,
    output mult_A, mult_B, mult_A_stb, mult_B_stb,
    input  mult_result, mult_result_ready,
    output mult_result_ack,
    output out_data, out_valid,
    input  out_ready,
    output timeout_err
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready,
    input  mult_A, mult_B, mult_A_stb, mult_B_stb,
    output mult_result, mult_result_ready,
    input  mult_result_ack,
    input  out_data, out_valid,
    output out_ready,
    input  timeout_err
  );

endinterface

// File: rtl/fbf_word_serializer.sv
// Holds the captured 512-bit product and streams word idx out.
// Ports: clk, load/din capture, en/idx select, data/valid/ready/fire.
module fbf_word_serializer
  import fbf_pkg::*;
(
  input  logic          clk,
  input  logic          load,
  input  logic [BW-1:0] din,
  input  logic          en,
  input  logic [3:0]    idx,
  output logic [WW-1:0] data,
  output logic          valid,
  input  logic          ready,
  output logic          fire
);

  logic [BW-1:0] word_buf;

  always_ff @(posedge clk) begin
    if (load) word_buf <= din;
  end

  // Gate data so the port reads zero whenever no word is offered.
  assign valid = en;
  assign data  = en ? word_buf[idx*WW +: WW] : '0;
  assign fire  = en && ready;

endmodule

// File: rtl/fbf_mult_host.sv
// Loads A and B word-by-word, strobes the multiplier, acks and streams the product.
// Ports: clk, reset (async active-low), bus (master). Option: FBF_HOST_TIMEOUT_EN.
module fbf_mult_host
  import fbf_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic             clk,
  input logic             reset,
  fbf_mult_host_if.master bus
);

  state_t        state, state_nx;
  logic [3:0]    k, k_nx;
  logic          live;
  logic [BW-1:0] mat_a, mat_b;
  logic          loading, accept, capture;
  logic          drain_en, fire, expired;

  assign loading  = (state == S_LOAD_A) || (state == S_LOAD_B);
  // live keeps in_ready low until the first edge after reset release.
  assign bus.in_ready = live && loading;
  assign accept   = bus.in_valid && bus.in_ready;
  assign capture  = (state == S_WAIT_RESULT) && bus.mult_result_ready;
  assign drain_en = (state == S_DRAIN);

  assign bus.mult_A_stb      = (state == S_STROBE);
  assign bus.mult_B_stb      = (state == S_STROBE);
  assign bus.mult_result_ack = (state == S_ACK);
  assign bus.mult_A          = mat_a;
  assign bus.mult_B          = mat_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_LOAD_A;
      k     <= '0;
      live  <= 1'b0;
    end else begin
      state <= state_nx;
      k     <= k_nx;
      live  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && state == S_LOAD_A) mat_a[k*WW +: WW] <= bus.in_data;
    if (accept && state == S_LOAD_B) mat_b[k*WW +: WW] <= bus.in_data;
  end

  always_comb begin
    state_nx = state;
    k_nx     = k;
    unique case (state)
      S_LOAD_A: begin
        if (accept) begin
          k_nx = k + 4'd1;
          if (k == 4'd15) state_nx = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        if (accept) begin
          k_nx = k + 4'd1;
          if (k == 4'd15) state_nx = S_STROBE;
        end
      end
      S_STROBE: state_nx = S_WAIT_RESULT;
      S_WAIT_RESULT: begin
        if (capture) begin
          state_nx = S_ACK;
        end else if (expired) begin
          state_nx = S_LOAD_A;
          k_nx     = '0;
        end
      end
      S_ACK: state_nx = S_DRAIN;
      S_DRAIN: begin
        if (fire) begin
          k_nx = k + 4'd1;
          if (k == 4'd15) state_nx = S_LOAD_A;
        end
      end
      default: begin
        state_nx = S_LOAD_A;
        k_nx     = '0;
      end
    endcase
  end

`ifdef FBF_HOST_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt;
  logic          err;

  assign expired = (state == S_WAIT_RESULT) && !bus.mult_result_ready &&
                   (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (state == S_WAIT_RESULT && !bus.mult_result_ready && !expired)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
      if (expired) err <= 1'b1;
    end
  end

  assign bus.timeout_err = err;
`else
  assign expired         = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  fbf_word_serializer u_ser (
    .clk   (clk),
    .load  (capture),
    .din   (bus.mult_result),
    .en    (drain_en),
    .idx   (k),
    .data  (bus.out_data),
    .valid (bus.out_valid),
    .ready (bus.out_ready),
    .fire  (fire)
  );

endmodule

// File: tb/tb_fbf_mult_host.sv
// Directed bench for fbf_mult_host with a behavioural 4x4 multiplier model.
// Build with FBF_HOST_TIMEOUT_EN to add the abort scenario.
module tb_fbf_mult_host;
  import fbf_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fbf_mult_host_if bus ();

  fbf_mult_host #(.TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

`ifdef FBF_HOST_TIMEOUT_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 20;
`endif

  int n_chk = 0;
  int n_pass = 0;
  int stb_a = 0;
  int stb_b = 0;
  int acks = 0;

  bit model_en = 1'b1;
  int extra = 0;

  logic [31:0] tb_b  [16] = '{
    32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
    32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
    32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
    32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
  logic [31:0] tb_b2 [16] = '{
    32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
    32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000,
    32'h41900000, 32'h41A00000, 32'h41B00000, 32'h41C00000,
    32'h41D00000, 32'h41E00000, 32'h41F00000, 32'h42000000};

  logic [BW-1:0] mat_i, mat_2i, mat_bv, mat_b2v;

  task automatic check(input string tag, input logic [BW-1:0] got,
                       input logic [BW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int f2i(logic [31:0] f);
    int e;
    logic [31:0] m;
    int v;
    if (f[30:0] == 31'd0) return 0;
    e = int'(f[30:23]) - 127;
    m = {8'd0, 1'b1, f[22:0]};
    v = int'(m >> (23 - e));
    return f[31] ? -v : v;
  endfunction

  function automatic logic [31:0] i2f(int v);
    int e;
    logic [31:0] m;
    logic s;
    if (v == 0) return 32'd0;
    s = (v < 0);
    m = s ? -v : v;
    e = 0;
    for (int i = 0; i < 31; i++) if (m[i]) e = i;
    m = m << (23 - e);
    return {s, 8'(127 + e), m[22:0]};
  endfunction

  function automatic logic [BW-1:0] matmul(logic [BW-1:0] a, logic [BW-1:0] b);
    logic [BW-1:0] c;
    int s;
    c = '0;
    for (int m = 0; m < 4; m++)
      for (int n = 0; n < 4; n++) begin
        s = 0;
        for (int j = 0; j < 4; j++)
          s += f2i(a[(4*m+j)*32 +: 32]) * f2i(b[(4*j+n)*32 +: 32]);
        c[(4*m+n)*32 +: 32] = i2f(s);
      end
    return c;
  endfunction

  // Multiplier model: answers LAT cycles after the strobe, optionally
  // holding ready for extra cycles with a corrupted payload.
  logic [BW-1:0] res;
  int pend = 0;
  int cd = 0;
  int left = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 0;
      left = 0;
      bus.mult_result_ready = 1'b0;
    end else begin
      if (bus.mult_A_stb && model_en) begin
        pend = 1;
        cd = LAT;
        res = matmul(bus.mult_A, bus.mult_B);
      end else if (pend != 0) begin
        cd--;
        if (cd == 0) begin
          pend = 0;
          left = 1 + extra;
        end
      end
      if (left > 0) begin
        bus.mult_result_ready = 1'b1;
        bus.mult_result = (left <= extra) ? ~res : res;
        left--;
      end else begin
        bus.mult_result_ready = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      stb_a += int'(bus.mult_A_stb);
      stb_b += int'(bus.mult_B_stb);
      acks  += int'(bus.mult_result_ack);
    end
  end

  task automatic send(input logic [31:0] w);
    int tmo;
    tmo = 0;
    bus.in_data = w;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && tmo < 100) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 100) check("send_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic send_mat(input logic [BW-1:0] m);
    for (int i = 0; i < 16; i++) send(m[i*32 +: 32]);
  endtask

  task automatic drain(input bit slow, input int nw,
                       output logic [BW-1:0] got, output int bad);
    int c;
    int n;
    int ph;
    bit stalled;
    logic [31:0] pd;
    c = 0; n = 0; ph = 0; stalled = 0; pd = '0;
    got = '0;
    bad = 0;
    while (n < nw && c < 400) begin
      bus.out_ready = slow ? (ph % 3 == 2) : 1'b1;
      ph++;
      if (stalled && (!bus.out_valid || bus.out_data !== pd)) bad++;
      if (bus.out_valid && bus.out_ready) begin
        got[n*32 +: 32] = bus.out_data;
        n++;
        stalled = 0;
      end else if (bus.out_valid) begin
        stalled = 1;
        pd = bus.out_data;
      end
      @(negedge clk);
      c++;
    end
    bus.out_ready = 1'b0;
    if (n < nw) check("drain_timeout", n, nw);
  endtask

  task automatic txn(input string tag, input logic [BW-1:0] a,
                     input logic [BW-1:0] b, input logic [BW-1:0] exp,
                     input bit slow);
    int s0a, s0b, a0, bad;
    logic [BW-1:0] got;
    s0a = stb_a; s0b = stb_b; a0 = acks;
    send_mat(a);
    send_mat(b);
    bus.in_valid = 1'b0;
    drain(slow, 16, got, bad);
    check({tag, "_data"}, got, exp);
    check({tag, "_stb_a"}, stb_a - s0a, 1);
    check({tag, "_stb_b"}, stb_b - s0b, 1);
    check({tag, "_ack"}, acks - a0, 1);
    check({tag, "_stall"}, bad, 0);
    check({tag, "_idle"}, {bus.out_valid, bus.in_ready}, 2'b01);
  endtask

  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check({tag, "_async"},
             {bus.in_ready, bus.mult_A_stb, bus.mult_B_stb,
              bus.mult_result_ack, bus.out_valid, bus.timeout_err,
              bus.out_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check({tag, "_rel"}, bus.in_ready, 0);
    @(negedge clk);
    check({tag, "_up"}, bus.in_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int bad, rdy_hi, c, a0;
    logic [BW-1:0] got;
    mat_i = '0;
    mat_2i = '0;
    for (int i = 0; i < 4; i++) begin
      mat_i[(5*i)*32 +: 32] = 32'h3F800000;
      mat_2i[(5*i)*32 +: 32] = 32'h40000000;
    end
    for (int i = 0; i < 16; i++) begin
      mat_bv[i*32 +: 32] = tb_b[i];
      mat_b2v[i*32 +: 32] = tb_b2[i];
    end
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.mult_result = '0;
    bus.mult_result_ready = 1'b0;

    do_reset("rst0");

    txn("ident", mat_i, mat_bv, mat_bv, 1'b0);
    txn("slow2i", mat_2i, mat_bv, mat_b2v, 1'b1);

    send_mat(mat_i);
    send_mat(mat_bv);
    bus.in_data = 32'hDEADBEEF;
    bus.in_valid = 1'b1;
    rdy_hi = 0;
    c = 0;
    while (!bus.out_valid && c < 60) begin
      if (bus.in_ready) rdy_hi++;
      @(negedge clk);
      c++;
    end
    bus.in_valid = 1'b0;
    drain(1'b0, 16, got, bad);
    check("hold_rdy", rdy_hi, 0);
    check("hold_data", got, mat_bv);
    txn("after_hold", mat_i, mat_bv, mat_bv, 1'b0);

    extra = 3;
    txn("long_rdy", mat_i, mat_bv, mat_bv, 1'b0);
    repeat (4) @(negedge clk);
    extra = 0;

    send_mat(mat_i);
    send_mat(mat_bv);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    do_reset("rst_wait");
    txn("post_wait", mat_2i, mat_bv, mat_b2v, 1'b0);

    send_mat(mat_i);
    send_mat(mat_bv);
    bus.in_valid = 1'b0;
    drain(1'b0, 5, got, bad);
    do_reset("rst_drain");
    txn("post_drain", mat_i, mat_bv, mat_bv, 1'b1);

`ifdef FBF_HOST_TIMEOUT_EN
    model_en = 1'b0;
    a0 = acks;
    send_mat(mat_i);
    send_mat(mat_bv);
    bus.in_valid = 1'b0;
    check("to_stb", bus.mult_A_stb, 1);
    repeat (8) @(negedge clk);
    check("to_pre", bus.timeout_err, 0);
    @(negedge clk);
    check("to_err", bus.timeout_err, 1);
    check("to_rdy", bus.in_ready, 1);
    check("to_noack", acks - a0, 0);
    model_en = 1'b1;
    txn("to_next", mat_i, mat_bv, mat_bv, 1'b0);
    check("to_sticky", bus.timeout_err, 1);
    do_reset("to_rst");
`else
    a0 = acks;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fbf_mult_host.md
FBF_MULT_HOST -- requirements
Module: fbf_mult_host

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: cycles to wait for mult_result_ready before abort (used only with FBF_HOST_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_data  input  32  IEEE-754 single operand word.
REQ-005 SHALL have port in_valid  input  1  in_data valid.
REQ-006 SHALL have port in_ready  output  1  block accepts in_data.
REQ-007 SHALL have port mult_A  output  512  matrix A, element (m,n) at bits [(4m+n)*32 +: 32].
REQ-008 SHALL have port mult_B  output  512  matrix B, same layout.
REQ-009 SHALL have port mult_A_stb  output  1  A valid strobe.
REQ-010 SHALL have port mult_B_stb  output  1  B valid strobe.
REQ-011 SHALL have port mult_result  input  512  product matrix, same layout.
REQ-012 SHALL have port mult_result_ready  input  1  product valid.
REQ-013 SHALL have port mult_result_ack  output  1  product consumed.
REQ-014 SHALL have port out_data  output  32  product word.
REQ-015 SHALL have port out_valid  output  1  out_data valid.
REQ-016 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-017 SHALL have port timeout_err  output  1  sticky abort flag (tied 0 without FBF_HOST_TIMEOUT_EN).

Function
REQ-018 SHALL implement states S_LOAD_A, S_LOAD_B, S_STROBE, S_WAIT_RESULT, S_ACK, S_DRAIN; 4-bit word index k.
REQ-019 SHALL in S_LOAD_A assert in_ready; each in_valid&&in_ready cycle write in_data to A element k (row-major), k+1; after k=15 go S_LOAD_B, k=0.
REQ-020 SHALL load B identically in S_LOAD_B; after k=15 go S_STROBE.
REQ-021 SHALL hold in_ready low in every state other than S_LOAD_A/S_LOAD_B.
REQ-022 SHALL in S_STROBE assert mult_A_stb and mult_B_stb together for exactly one cycle, then go S_WAIT_RESULT; strobes low otherwise.
REQ-023 SHALL keep mult_A/mult_B stable from S_STROBE until S_DRAIN completes.
REQ-024 SHALL in S_WAIT_RESULT, on mult_result_ready high, capture mult_result into a 512-bit buffer and go S_ACK.
REQ-025 SHALL in S_ACK drive mult_result_ack high for exactly one cycle, then go S_DRAIN.
REQ-026 SHALL in S_DRAIN present buffer word k on out_data with out_valid high; advance k on out_valid&&out_ready; after word 15 go S_LOAD_A, k=0.
REQ-027 SHALL hold out_data/out_valid stable while out_valid&&!out_ready.
REQ-028 SHALL ignore mult_result_ready outside S_WAIT_RESULT.
REQ-029 SHALL pass data bit-exact; no arithmetic on words.

Reset
REQ-030 SHALL on reset low, immediately and regardless of state: state=S_LOAD_A, k=0, in_ready=0, mult_A_stb=mult_B_stb=0, mult_result_ack=0, out_valid=0, out_data=0, timeout_err=0; in_ready rises first cycle after release.
REQ-031 SHALL not require reset of matrix/result buffers.

Configuration
REQ-032 SHALL, with FBF_HOST_TIMEOUT_EN defined, count cycles in S_WAIT_RESULT; on reaching TIMEOUT_CYCLES without mult_result_ready, set timeout_err (sticky until reset) and go S_LOAD_A, k=0, no ack issued.
REQ-033 SHALL, without FBF_HOST_TIMEOUT_EN, contain no counter, wait indefinitely, and tie timeout_err to 0.

Structure
REQ-034 SHALL place state encodings, matrix dimension (4), word width (32) and bus width (512) in shared package fbf_pkg.
REQ-035 SHALL use one sub-module fbf_word_serializer (512-bit buffer to 32-bit valid/ready stream) for S_DRAIN.

Verification
REQ-036 SHALL test: A=identity (1.0=32'h3F800000 diag), B=elements 1..16 as floats; model multiplier returns A*B after 20 cycles -> out stream equals B words in order, one strobe pulse, one ack pulse.
REQ-037 SHALL test: out_ready toggled 1-of-3 cycles -> all 16 words delivered once, stable while stalled.
REQ-038 SHALL test: in_valid held high during S_WAIT_RESULT -> in_ready=0, no words consumed, next transaction loads correctly.
REQ-039 SHALL test: reset asserted mid S_WAIT_RESULT and mid S_DRAIN -> all outputs at reset values asynchronously, clean next transaction.
REQ-040 SHALL test with FBF_HOST_TIMEOUT_EN, TIMEOUT_CYCLES=8: model never responds -> timeout_err=1 after 8 waiting cycles, mult_result_ack never asserted, in_ready=1 next cycle.
REQ-041 SHALL test: mult_result_ready high for 3 cycles after ack -> only one capture, one ack.
